// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB instruction bus carrying the fields captured by the MEM/WB register.

interface wb_stage_if;
   logic        valid;
   logic [31:0] pc;
   logic [31:0] alu;
   logic [31:0] rdata;
   logic [31:0] imm;
   logic [4:0]  wr;
   logic        we;
   logic [1:0]  wd_sel;
   logic [2:0]  ld_type;

   modport master (
      output valid, pc, alu, rdata, imm, wr, we, wd_sel, ld_type
   );

   modport slave (
      input  valid, pc, alu, rdata, imm, wr, we, wd_sel, ld_type
   );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, write-data select and load alignment, RF write-through bypass, instret.
// Defining WB_TRACE_EN adds the debug_wb_* trace outputs.

module wb_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        stall_i,
   input  logic        flush_i,
   wb_stage_if.slave   mem,
   output logic [4:0]  wR_o,
   output logic [31:0] wD_o,
   output logic        WE_o,
   input  logic [4:0]  rR1_i,
   input  logic [4:0]  rR2_i,
   input  logic [31:0] rf_rD1_i,
   input  logic [31:0] rf_rD2_i,
   output logic [31:0] id_rD1_o,
   output logic [31:0] id_rD2_o,
   output logic [31:0] instret_o
`ifdef WB_TRACE_EN
   ,
   output logic        debug_wb_have_inst_o,
   output logic [31:0] debug_wb_pc_o,
   output logic        debug_wb_ena_o,
   output logic [4:0]  debug_wb_reg_o,
   output logic [31:0] debug_wb_value_o
`endif
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] alu_q;
   logic [31:0] rdata_q;
   logic [31:0] imm_q;
   logic [4:0]  wr_q;
   logic        we_q;
   logic [1:0]  wd_sel_q;
   logic [2:0]  ld_type_q;
   logic [31:0] instret_q;

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q   <= 1'b0;
         pc_q      <= RESET_PC;
         alu_q     <= 32'd0;
         rdata_q   <= 32'd0;
         imm_q     <= 32'd0;
         wr_q      <= 5'd0;
         we_q      <= 1'b0;
         wd_sel_q  <= 2'd0;
         ld_type_q <= 3'd0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (!stall_i) begin
         valid_q   <= mem.valid;
         pc_q      <= mem.pc;
         alu_q     <= mem.alu;
         rdata_q   <= mem.rdata;
         imm_q     <= mem.imm;
         wr_q      <= mem.wr;
         we_q      <= mem.we;
         wd_sel_q  <= mem.wd_sel;
         ld_type_q <= mem.ld_type;
      end
   end

   // Flush overrides stall, so the instruction leaving WB on a flush still retires.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         instret_q <= 32'd0;
      end else if (valid_q && (!stall_i || flush_i)) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   always_comb begin
      ld_byte = rdata_q[7:0];
      case (alu_q[1:0])
         2'd0:    ld_byte = rdata_q[7:0];
         2'd1:    ld_byte = rdata_q[15:8];
         2'd2:    ld_byte = rdata_q[23:16];
         default: ld_byte = rdata_q[31:24];
      endcase
      ld_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];

      case (ld_type_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = rdata_q;
      endcase

      case (wd_sel_q)
         2'b00:   wD_o = alu_q;
         2'b01:   wD_o = ld_data;
         2'b10:   wD_o = pc_q + 32'd4;
         default: wD_o = imm_q;
      endcase
   end

   assign wR_o      = wr_q;
   assign WE_o      = valid_q & we_q & (wr_q != 5'd0);
   assign instret_o = instret_q;

   // RF commits on the edge, so ID sees the in-flight write through this path.
   assign id_rD1_o = (WE_o && (rR1_i == wR_o) && (rR1_i != 5'd0)) ? wD_o : rf_rD1_i;
   assign id_rD2_o = (WE_o && (rR2_i == wR_o) && (rR2_i != 5'd0)) ? wD_o : rf_rD2_i;

`ifdef WB_TRACE_EN
   assign debug_wb_have_inst_o = valid_q;
   assign debug_wb_pc_o        = pc_q;
   assign debug_wb_ena_o       = WE_o;
   assign debug_wb_reg_o       = wR_o;
   assign debug_wb_value_o     = wD_o;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven vectors for write-data/alignment plus directed bypass, stall/flush,
// reset and counter-wrap sequences for wb_stage.

module tb_wb_stage;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        stall_i;
   logic        flush_i;
   logic [4:0]  wR_o;
   logic [31:0] wD_o;
   logic        WE_o;
   logic [4:0]  rR1_i, rR2_i;
   logic [31:0] rf_rD1_i, rf_rD2_i;
   logic [31:0] id_rD1_o, id_rD2_o;
   logic [31:0] instret_o;
`ifdef WB_TRACE_EN
   logic        debug_wb_have_inst_o;
   logic [31:0] debug_wb_pc_o;
   logic        debug_wb_ena_o;
   logic [4:0]  debug_wb_reg_o;
   logic [31:0] debug_wb_value_o;
`endif

   wb_stage_if mem_bus ();

   wb_stage #(.RESET_PC(32'h0000_1000)) dut (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .stall_i   (stall_i),
      .flush_i   (flush_i),
      .mem       (mem_bus.slave),
      .wR_o      (wR_o),
      .wD_o      (wD_o),
      .WE_o      (WE_o),
      .rR1_i     (rR1_i),
      .rR2_i     (rR2_i),
      .rf_rD1_i  (rf_rD1_i),
      .rf_rD2_i  (rf_rD2_i),
      .id_rD1_o  (id_rD1_o),
      .id_rD2_o  (id_rD2_o),
      .instret_o (instret_o)
`ifdef WB_TRACE_EN
      ,
      .debug_wb_have_inst_o (debug_wb_have_inst_o),
      .debug_wb_pc_o        (debug_wb_pc_o),
      .debug_wb_ena_o       (debug_wb_ena_o),
      .debug_wb_reg_o       (debug_wb_reg_o),
      .debug_wb_value_o     (debug_wb_value_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  wd_sel;
      logic [2:0]  ld_type;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  wr;
      logic        we;
      logic [31:0] exp_wd;
      logic        exp_we;
   } vec_t;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_ret = 32'd0;
   logic        model_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] lt,
                        input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [4:0] wr, input logic we);
      mem_bus.valid   = v;
      mem_bus.wd_sel  = sel;
      mem_bus.ld_type = lt;
      mem_bus.alu     = alu;
      mem_bus.rdata   = rdata;
      mem_bus.pc      = pc;
      mem_bus.imm     = imm;
      mem_bus.wr      = wr;
      mem_bus.we      = we;
   endtask

   // Advance one edge; the counter model retires whatever was in WB unless held by a lone stall.
   task automatic step(input logic st, input logic fl);
      stall_i = st;
      flush_i = fl;
      @(posedge clk_i);
      if (model_valid && (!st || fl)) exp_ret = exp_ret + 32'd1;
      if (fl) model_valid = 1'b0;
      else if (!st) model_valid = mem_bus.valid;
      #1;
   endtask

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{2'b01, 3'b000, 32'h0000_0001, 32'h8899_AABB, 32'h0, 32'h0, 5'd3, 1'b1, 32'hFFFF_FFAA, 1'b1};
      vecs[1]  = '{2'b01, 3'b100, 32'h0000_1003, 32'h8899_AABB, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0000_0088, 1'b1};
      vecs[2]  = '{2'b01, 3'b001, 32'h0000_0002, 32'h8899_AABB, 32'h0, 32'h0, 5'd5, 1'b1, 32'hFFFF_8899, 1'b1};
      vecs[3]  = '{2'b01, 3'b101, 32'h0000_0000, 32'h8899_AABB, 32'h0, 32'h0, 5'd6, 1'b1, 32'h0000_AABB, 1'b1};
      vecs[4]  = '{2'b01, 3'b010, 32'h0000_0000, 32'h8899_AABB, 32'h0, 32'h0, 5'd7, 1'b1, 32'h8899_AABB, 1'b1};
      vecs[5]  = '{2'b01, 3'b001, 32'h0000_0003, 32'h8899_AABB, 32'h0, 32'h0, 5'd8, 1'b1, 32'hFFFF_8899, 1'b1};
      vecs[6]  = '{2'b01, 3'b011, 32'h0000_0001, 32'h8899_AABB, 32'h0, 32'h0, 5'd9, 1'b1, 32'h8899_AABB, 1'b1};
      vecs[7]  = '{2'b10, 3'b000, 32'h0000_0000, 32'h0, 32'hFFFF_FFFC, 32'h0, 5'd1, 1'b1, 32'h0000_0000, 1'b1};
      vecs[8]  = '{2'b11, 3'b000, 32'h0000_0000, 32'h0, 32'h0, 32'h1234_5000, 5'd2, 1'b1, 32'h1234_5000, 1'b1};
      vecs[9]  = '{2'b00, 3'b000, 32'hCAFE_0000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 32'hCAFE_0000, 1'b0};
      vecs[10] = '{2'b00, 3'b000, 32'h0000_0055, 32'h0, 32'h0, 32'h0, 5'd7, 1'b0, 32'h0000_0055, 1'b0};
      vecs[11] = '{2'b01, 3'b100, 32'h0000_0002, 32'h0080_0000, 32'h0, 32'h0, 5'd10, 1'b1, 32'h0000_0080, 1'b1};
      vecs[12] = '{2'b01, 3'b000, 32'h0000_0002, 32'h0080_0000, 32'h0, 32'h0, 5'd11, 1'b1, 32'hFFFF_FF80, 1'b1};

      rst_n_i = 1'b0;
      stall_i = 1'b0;
      flush_i = 1'b0;
      rR1_i = 5'd0;
      rR2_i = 5'd0;
      rf_rD1_i = 32'h1111_0001;
      rf_rD2_i = 32'h2222_0002;
      drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
      #12;
      chk("reset_we", {31'd0, WE_o}, 32'd0);
      chk("reset_wd", wD_o, 32'd0);
      chk("reset_instret", instret_o, 32'd0);
`ifdef WB_TRACE_EN
      chk("reset_trace_pc", debug_wb_pc_o, 32'h0000_1000);
`endif
      @(negedge clk_i);
      rst_n_i = 1'b1;

      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].wd_sel, vecs[i].ld_type, vecs[i].alu, vecs[i].rdata, vecs[i].pc,
               vecs[i].imm, vecs[i].wr, vecs[i].we);
         step(1'b0, 1'b0);
         chk($sformatf("vec%0d_wd", i), wD_o, vecs[i].exp_wd);
         chk($sformatf("vec%0d_we", i), {31'd0, WE_o}, {31'd0, vecs[i].exp_we});
         chk($sformatf("vec%0d_wr", i), {27'd0, wR_o}, {27'd0, vecs[i].wr});
         chk($sformatf("vec%0d_instret", i), instret_o, exp_ret);
      end

      // Bypass: WB writes x5.
      drive(1'b1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1);
      step(1'b0, 1'b0);
      rR1_i = 5'd5; rR2_i = 5'd6; rf_rD1_i = 32'd1; rf_rD2_i = 32'd2;
      #1;
      chk("byp1_hit", id_rD1_o, 32'hDEAD_BEEF);
      chk("byp2_miss", id_rD2_o, 32'd2);
      rR1_i = 5'd6; rR2_i = 5'd5;
      #1;
      chk("byp1_miss", id_rD1_o, 32'd1);
      chk("byp2_hit", id_rD2_o, 32'hDEAD_BEEF);
      // Same with wr=0: x0 never forwarded.
      drive(1'b1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1);
      step(1'b0, 1'b0);
      rR1_i = 5'd0; rR2_i = 5'd0;
      #1;
      chk("byp_x0_p1", id_rD1_o, 32'd1);
      chk("byp_x0_p2", id_rD2_o, 32'd2);

      // Stall three cycles, then flush+stall together.
      drive(1'b1, 2'b00, 3'b000, 32'h1111_1111, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1);
      step(1'b0, 1'b0);
      drive(1'b1, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 1'b1);
      for (int c = 0; c < 3; c++) begin
         step(1'b1, 1'b0);
         chk($sformatf("stall%0d_wd", c), wD_o, 32'h1111_1111);
         chk($sformatf("stall%0d_wr", c), {27'd0, wR_o}, 32'd9);
         chk($sformatf("stall%0d_we", c), {31'd0, WE_o}, 32'd1);
         chk($sformatf("stall%0d_instret", c), instret_o, exp_ret);
      end
      step(1'b1, 1'b1);
      chk("flush_we", {31'd0, WE_o}, 32'd0);
      chk("flush_instret", instret_o, exp_ret);
`ifdef WB_TRACE_EN
      chk("flush_trace_have", {31'd0, debug_wb_have_inst_o}, 32'd0);
`endif

      // Counter wrap via forced preload.
      drive(1'b1, 2'b00, 3'b000, 32'h0000_00A0, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1);
      step(1'b0, 1'b0);
      @(negedge clk_i);
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      #1;
      exp_ret = 32'hFFFF_FFFF;
      chk("wrap_preload", instret_o, exp_ret);
      step(1'b0, 1'b0);
      chk("wrap_zero", instret_o, 32'd0);
      chk("wrap_model", instret_o, exp_ret);

      // Asynchronous reset mid-cycle with a valid instruction in WB.
      drive(1'b1, 2'b11, 3'b000, 32'h0, 32'h0, 32'h0, 32'h7777_0000, 5'd13, 1'b1);
      step(1'b0, 1'b0);
      rR1_i = 5'd13; rf_rD1_i = 32'h0000_00AB;
      #1;
      chk("pre_reset_byp", id_rD1_o, 32'h7777_0000);
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("mid_reset_we", {31'd0, WE_o}, 32'd0);
      chk("mid_reset_wr", {27'd0, wR_o}, 32'd0);
      chk("mid_reset_wd", wD_o, 32'd0);
      chk("mid_reset_instret", instret_o, 32'd0);
      chk("mid_reset_byp", id_rD1_o, 32'h0000_00AB);
`ifdef WB_TRACE_EN
      chk("mid_reset_trace_val", debug_wb_value_o, 32'd0);
      chk("mid_reset_trace_pc", debug_wb_pc_o, 32'h0000_1000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
